// File: rtl/uart_rx.sv
// uart_rx - UART receiver with start-bit detection and mid-bit sampling.
//
// The serial line is synchronised (2 flops), a 1->0 transition starts a frame,
// every bit is sampled at prescale/2, data are shifted in LSB-first, optional
// parity and the stop bit are checked, and a good word is presented on p_data
// with a single-cycle data_valid strobe.
//
// Optional build macro: UART_RX_MAJORITY_EN
//   defined   - 2-of-3 majority of samples at S-1, S, S+1, decided at S+1
//   undefined - single sample at S, decided at S
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   rx_in      serial line, idle high, asynchronous to clk
//   prescale   clk cycles per bit (8, 16 or 32), latched at start detection
//   par_en     1 = parity bit follows the data, latched at start detection
//   par_typ    0 = even, 1 = odd parity, latched at start detection
//   p_data     last correctly received word
//   data_valid one-cycle pulse when p_data is updated
//   par_err    one-cycle pulse on parity mismatch
//   stop_err   one-cycle pulse when the stop bit is sampled low
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stop_err
);

    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BCW-1:0]        LAST_BIT = BCW'(DATA_WIDTH - 1);
    localparam logic [BCW-1:0]        BIT_ONE  = BCW'(1);
    localparam logic [PRESCALE_W-1:0] ONE      = PRESCALE_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state_q, state_d;
    logic                  sync1_q, sync2_q, rx_prev_q;
    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  par_flag_q, par_flag_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stop_err_q, stop_err_d;

    logic                  rx_s, fall, last, dec, bit_val;
    logic [PRESCALE_W-1:0] samp_pt;

    assign rx_s    = sync2_q;
    assign fall    = rx_prev_q & ~rx_s;
    assign samp_pt = presc_q >> 1;
    assign last    = (edge_cnt_q == presc_q - ONE);

`ifdef UART_RX_MAJORITY_EN
    logic samp_a_q, samp_a_d, samp_b_q, samp_b_d;
    // Samples at S-1 and S are held; the third is the live value at S+1.
    assign dec     = (edge_cnt_q == samp_pt + ONE);
    assign bit_val = (samp_a_q & samp_b_q) | (samp_a_q & rx_s) | (samp_b_q & rx_s);
`else
    assign dec     = (edge_cnt_q == samp_pt);
    assign bit_val = rx_s;
`endif

    always_comb begin
        state_d      = state_q;
        edge_cnt_d   = last ? '0 : edge_cnt_q + ONE;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        presc_d      = presc_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        par_flag_d   = par_flag_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stop_err_d   = 1'b0;
`ifdef UART_RX_MAJORITY_EN
        samp_a_d     = samp_a_q;
        samp_b_d     = samp_b_q;
        if (edge_cnt_q == samp_pt - ONE) samp_a_d = rx_s;
        if (edge_cnt_q == samp_pt)       samp_b_d = rx_s;
`endif
        unique case (state_q)
            S_IDLE: begin
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
                if (fall) begin
                    state_d    = S_START;
                    presc_d    = prescale;
                    par_en_d   = par_en;
                    par_typ_d  = par_typ;
                    par_flag_d = 1'b0;
                end
            end
            S_START: begin
                if (dec && bit_val) begin
                    // Start bit not low at its centre: treat as a glitch.
                    state_d    = S_IDLE;
                    edge_cnt_d = '0;
                end else if (last) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (dec) shift_d = {bit_val, shift_q[DATA_WIDTH-1:1]};
                if (last) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                    end
                end
            end
            S_PARITY: begin
                if (dec) par_flag_d = bit_val ^ (^shift_q) ^ par_typ_q;
                if (last) state_d = S_STOP;
            end
            S_STOP: begin
                // Leave at the sample point so the next start edge is not missed.
                if (dec) begin
                    state_d    = S_IDLE;
                    edge_cnt_d = '0;
                    stop_err_d = ~bit_val;
                    par_err_d  = par_flag_q;
                    if (bit_val && !par_flag_q) begin
                        data_valid_d = 1'b1;
                        p_data_d     = shift_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            rx_prev_q    <= 1'b1;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            presc_q      <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_flag_q   <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stop_err_q   <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
            samp_a_q     <= 1'b1;
            samp_b_q     <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            sync1_q      <= rx_in;
            sync2_q      <= sync1_q;
            rx_prev_q    <= sync2_q;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            presc_q      <= presc_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            par_flag_q   <= par_flag_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stop_err_q   <= stop_err_d;
`ifdef UART_RX_MAJORITY_EN
            samp_a_q     <= samp_a_d;
            samp_b_q     <= samp_b_d;
`endif
        end
    end

    assign p_data     = p_data_q;
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign stop_err   = stop_err_q;

endmodule
